// File: rtl/mipi_csi2_pkg.sv
// Shared CSI-2 header definitions: packet classing, Hamming column table and controller states.
package mipi_csi2_pkg;

   localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

   // ECC of a header with only D[i] set; a syndrome equal to entry i points at D[i].
   localparam logic [5:0] ECC_COL [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
   };

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_CHECK   = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CRC     = 3'd4
   } state_t;

endpackage

// File: rtl/mipi_ecc_syndrome.sv
// Combinational CSI-2 header ECC check: recomputes parity, corrects single-bit errors, flags the rest.
module mipi_ecc_syndrome
   import mipi_csi2_pkg::*;
(
   input  logic [23:0] data,
   input  logic [5:0]  ecc,
   output logic [23:0] data_fixed,
   output logic        corrected,
   output logic        error
);

   logic [5:0] calc;
   logic [5:0] syn;
   logic       hit;

   assign calc[0] = data[0]  ^ data[1]  ^ data[2]  ^ data[4]  ^ data[5]  ^ data[7]  ^ data[10] ^
                    data[11] ^ data[13] ^ data[16] ^ data[20] ^ data[21] ^ data[22] ^ data[23];
   assign calc[1] = data[0]  ^ data[1]  ^ data[3]  ^ data[4]  ^ data[6]  ^ data[8]  ^ data[10] ^
                    data[12] ^ data[14] ^ data[17] ^ data[20] ^ data[21] ^ data[22] ^ data[23];
   assign calc[2] = data[0]  ^ data[2]  ^ data[3]  ^ data[5]  ^ data[6]  ^ data[9]  ^ data[11] ^
                    data[12] ^ data[15] ^ data[18] ^ data[20] ^ data[21] ^ data[22];
   assign calc[3] = data[1]  ^ data[2]  ^ data[3]  ^ data[7]  ^ data[8]  ^ data[9]  ^ data[13] ^
                    data[14] ^ data[15] ^ data[19] ^ data[20] ^ data[21] ^ data[23];
   assign calc[4] = data[4]  ^ data[5]  ^ data[6]  ^ data[7]  ^ data[8]  ^ data[9]  ^ data[16] ^
                    data[17] ^ data[18] ^ data[19] ^ data[20] ^ data[22] ^ data[23];
   assign calc[5] = data[10] ^ data[11] ^ data[12] ^ data[13] ^ data[14] ^ data[15] ^ data[16] ^
                    data[17] ^ data[18] ^ data[19] ^ data[21] ^ data[22] ^ data[23];

   assign syn = calc ^ ecc;

   always_comb begin
      data_fixed = data;
      hit        = 1'b0;
      corrected  = 1'b0;
      error      = 1'b0;
      if (syn != 6'd0) begin
         for (int i = 0; i < 24; i++) begin
            if (syn == ECC_COL[i]) begin
               data_fixed[i] = ~data[i];
               hit           = 1'b1;
            end
         end
         // A one-hot syndrome means the ECC byte itself took the hit.
         if ((syn & (syn - 6'd1)) == 6'd0) begin
            hit = 1'b1;
         end
         corrected = hit;
         error     = ~hit;
      end
   end

endmodule

// File: rtl/mipi_pkt_header_ctrl.sv
// CSI-2 packet sequencer on the merged byte stream: header capture, ECC check, payload and CRC counting.
//  state   | meaning
//  IDLE    | waiting for SoT
//  HDR     | collecting header bytes 0..3
//  CHECK   | one cycle, syndrome evaluated, header fields registered
//  PAYLOAD | forwarding long-packet payload, counting WC down
//  CRC     | swallowing the 2 checksum bytes
module mipi_pkt_header_ctrl
   import mipi_csi2_pkg::*;
#(
   parameter int P_WC_WIDTH = 16
)(
   input  logic                  I_clk,
   input  logic                  I_rst_n,
   input  logic                  I_Pkt_Start,
   input  logic                  I_Pkt_End,
   input  logic [7:0]            I_Byte_Data,
   input  logic                  I_Byte_Valid,
   output logic                  O_Hdr_Valid,
   output logic [1:0]            O_Pkt_VC,
   output logic [5:0]            O_Pkt_DT,
   output logic [P_WC_WIDTH-1:0] O_Pkt_WC,
   output logic                  O_Ecc_Corrected,
   output logic                  O_Ecc_Error,
   output logic [7:0]            O_Payload_Data,
   output logic                  O_Payload_Valid,
   output logic                  O_Payload_Last,
   output logic                  O_Pkt_Abort,
   output logic                  O_Busy
);

   state_t                state, state_next;
   logic [1:0]            hdr_cnt;
   logic                  crc_cnt;
   logic [23:0]           hdr_data;
   logic [5:0]            hdr_ecc;
   logic [P_WC_WIDTH-1:0] wc_cnt;

   logic [23:0]           fix_data;
   logic                  fix_corr, fix_err;
   logic [P_WC_WIDTH-1:0] wc_fix;
   logic                  is_short;

   logic abort, hdr_take, hdr_clr, pay_take, pay_last, wc_load, crc_take, hdr_emit, err_emit;

   mipi_ecc_syndrome u_ecc (
      .data       (hdr_data),
      .ecc        (hdr_ecc),
      .data_fixed (fix_data),
      .corrected  (fix_corr),
      .error      (fix_err)
   );

   assign wc_fix   = P_WC_WIDTH'(fix_data[23:8]);
   assign is_short = (fix_data[5:0] <= DT_SHORT_MAX);

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      abort      = 1'b0;
      hdr_take   = 1'b0;
      hdr_clr    = 1'b0;
      pay_take   = 1'b0;
      pay_last   = 1'b0;
      wc_load    = 1'b0;
      crc_take   = 1'b0;
      hdr_emit   = 1'b0;
      err_emit   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (I_Pkt_Start) begin
               state_next = ST_HDR;
               hdr_clr    = 1'b1;
            end
         end
         ST_HDR: begin
            if (I_Byte_Valid) begin
               hdr_take = 1'b1;
               if (hdr_cnt == 2'd3) state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            hdr_emit = ~fix_err;
            err_emit = fix_err;
            if (fix_err || is_short) begin
               state_next = ST_IDLE;
            end else if (wc_fix == '0) begin
               state_next = ST_CRC;
               crc_take   = I_Byte_Valid;
            end else begin
               state_next = ST_PAYLOAD;
               wc_load    = 1'b1;
               if (I_Byte_Valid) begin
                  pay_take = 1'b1;
                  if (wc_fix == P_WC_WIDTH'(1)) begin
                     pay_last   = 1'b1;
                     state_next = ST_CRC;
                  end
               end
            end
         end
         ST_PAYLOAD: begin
            if (I_Byte_Valid) begin
               pay_take = 1'b1;
               if (wc_cnt == P_WC_WIDTH'(1)) begin
                  pay_last   = 1'b1;
                  state_next = ST_CRC;
               end
            end
         end
         ST_CRC: begin
            if (I_Byte_Valid) begin
               crc_take = 1'b1;
               if (crc_cnt) state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Lane events override whatever the current byte would have done.
      if (state != ST_IDLE && (I_Pkt_End || I_Pkt_Start)) begin
         abort      = 1'b1;
         hdr_take   = 1'b0;
         pay_take   = 1'b0;
         pay_last   = 1'b0;
         wc_load    = 1'b0;
         crc_take   = 1'b0;
         hdr_emit   = 1'b0;
         err_emit   = 1'b0;
         hdr_clr    = ~I_Pkt_End;
         state_next = I_Pkt_End ? ST_IDLE : ST_HDR;
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         hdr_cnt         <= '0;
         crc_cnt         <= 1'b0;
         hdr_data        <= '0;
         hdr_ecc         <= '0;
         wc_cnt          <= '0;
         O_Hdr_Valid     <= 1'b0;
         O_Pkt_VC        <= '0;
         O_Pkt_DT        <= '0;
         O_Pkt_WC        <= '0;
         O_Ecc_Corrected <= 1'b0;
         O_Ecc_Error     <= 1'b0;
         O_Payload_Data  <= '0;
         O_Payload_Valid <= 1'b0;
         O_Payload_Last  <= 1'b0;
         O_Pkt_Abort     <= 1'b0;
         O_Busy          <= 1'b0;
      end else begin
         if (hdr_clr) begin
            hdr_cnt <= '0;
         end else if (hdr_take) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
               2'd0:    hdr_data[7:0]   <= I_Byte_Data;
               2'd1:    hdr_data[15:8]  <= I_Byte_Data;
               2'd2:    hdr_data[23:16] <= I_Byte_Data;
               default: hdr_ecc         <= I_Byte_Data[5:0];
            endcase
         end

         if (state_next != ST_CRC) crc_cnt <= 1'b0;
         else if (crc_take)        crc_cnt <= 1'b1;

         if (wc_load)       wc_cnt <= wc_fix - P_WC_WIDTH'(pay_take);
         else if (pay_take) wc_cnt <= wc_cnt - P_WC_WIDTH'(1);

         O_Hdr_Valid     <= hdr_emit;
         O_Ecc_Corrected <= hdr_emit & fix_corr;
         O_Ecc_Error     <= err_emit;
         if (hdr_emit) begin
            O_Pkt_VC <= fix_data[7:6];
            O_Pkt_DT <= fix_data[5:0];
            O_Pkt_WC <= wc_fix;
         end

         O_Payload_Valid <= pay_take;
         O_Payload_Last  <= pay_last;
         if (pay_take) O_Payload_Data <= I_Byte_Data;

         O_Pkt_Abort <= abort;
         O_Busy      <= (state_next != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_mipi_pkt_header_ctrl.sv
// Directed bench for mipi_pkt_header_ctrl: short-header vector table plus long-packet sequences.
module tb_mipi_pkt_header_ctrl;

   logic        I_clk;
   logic        I_rst_n;
   logic        I_Pkt_Start, I_Pkt_End, I_Byte_Valid;
   logic [7:0]  I_Byte_Data;
   logic        O_Hdr_Valid, O_Ecc_Corrected, O_Ecc_Error;
   logic [1:0]  O_Pkt_VC;
   logic [5:0]  O_Pkt_DT;
   logic [15:0] O_Pkt_WC;
   logic [7:0]  O_Payload_Data;
   logic        O_Payload_Valid, O_Payload_Last, O_Pkt_Abort, O_Busy;

   mipi_pkt_header_ctrl #(.P_WC_WIDTH(16)) dut (
      .I_clk           (I_clk),
      .I_rst_n         (I_rst_n),
      .I_Pkt_Start     (I_Pkt_Start),
      .I_Pkt_End       (I_Pkt_End),
      .I_Byte_Data     (I_Byte_Data),
      .I_Byte_Valid    (I_Byte_Valid),
      .O_Hdr_Valid     (O_Hdr_Valid),
      .O_Pkt_VC        (O_Pkt_VC),
      .O_Pkt_DT        (O_Pkt_DT),
      .O_Pkt_WC        (O_Pkt_WC),
      .O_Ecc_Corrected (O_Ecc_Corrected),
      .O_Ecc_Error     (O_Ecc_Error),
      .O_Payload_Data  (O_Payload_Data),
      .O_Payload_Valid (O_Payload_Valid),
      .O_Payload_Last  (O_Payload_Last),
      .O_Pkt_Abort     (O_Pkt_Abort),
      .O_Busy          (O_Busy)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      logic        hv, err, corr;
      logic [1:0]  vc;
      logic [5:0]  dt;
      logic [15:0] wc;
   } vec_t;

   vec_t        vt [8];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_pay, n_last;
   logic [7:0]  pay_q [$];
   logic [7:0]  last_byte;
   logic [1:0]  last_vc;
   logic [5:0]  last_dt;
   logic [15:0] last_wc;
   logic [7:0]  exp_pay [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      n_pay     = 0;
      n_last    = 0;
      last_byte = 8'h00;
      pay_q.delete();
   endtask

   task automatic step(input logic s, input logic e, input logic v, input logic [7:0] d);
      I_Pkt_Start  = s;
      I_Pkt_End    = e;
      I_Byte_Valid = v;
      I_Byte_Data  = d;
      @(posedge I_clk);
      #1;
      if (O_Payload_Valid) begin
         pay_q.push_back(O_Payload_Data);
         n_pay++;
         if (O_Payload_Last) begin
            n_last++;
            last_byte = O_Payload_Data;
         end
      end
   endtask

   // Start is given with a junk byte that must not become header byte 0.
   task automatic send_hdr(input logic [7:0] b0, b1, b2, b3);
      step(1'b1, 1'b0, 1'b1, 8'hE7);
      check("busy_after_start", O_Busy, 1);
      step(1'b0, 1'b0, 1'b1, b0);
      step(1'b0, 1'b0, 1'b1, b1);
      step(1'b0, 1'b0, 1'b1, b2);
      step(1'b0, 1'b0, 1'b1, b3);
      check("hv_not_early", O_Hdr_Valid, 0);
   endtask

   initial begin
      vt[0] = '{8'h00, 8'h01, 8'h00, 8'h1A, 1'b1, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0001};
      vt[1] = '{8'h01, 8'h01, 8'h00, 8'h1A, 1'b1, 1'b0, 1'b1, 2'd0, 6'h00, 16'h0001};
      vt[2] = '{8'h00, 8'h01, 8'h00, 8'h1B, 1'b1, 1'b0, 1'b1, 2'd0, 6'h00, 16'h0001};
      vt[3] = '{8'h00, 8'h01, 8'h00, 8'hDA, 1'b1, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0001};
      vt[4] = '{8'h41, 8'h34, 8'h12, 8'h10, 1'b1, 1'b0, 1'b0, 2'd1, 6'h01, 16'h1234};
      vt[5] = '{8'h41, 8'h34, 8'h02, 8'h10, 1'b1, 1'b0, 1'b1, 2'd1, 6'h01, 16'h1234};
      vt[6] = '{8'h00, 8'h01, 8'h00, 8'h25, 1'b0, 1'b1, 1'b0, 2'd0, 6'h00, 16'h0000};
      vt[7] = '{8'h0F, 8'h00, 8'h00, 8'h0F, 1'b1, 1'b0, 1'b0, 2'd0, 6'h0F, 16'h0000};

      I_rst_n = 1'b0;
      I_Pkt_Start = 1'b0; I_Pkt_End = 1'b0; I_Byte_Valid = 1'b0; I_Byte_Data = 8'h00;
      clear_log();
      repeat (3) @(posedge I_clk);
      #1;
      check("rst_hv", O_Hdr_Valid, 0);
      check("rst_busy", O_Busy, 0);
      check("rst_wc", O_Pkt_WC, 0);
      check("rst_pay_valid", O_Payload_Valid, 0);
      check("rst_abort", O_Pkt_Abort, 0);
      I_rst_n = 1'b1;
      last_vc = 2'd0; last_dt = 6'h00; last_wc = 16'h0000;

      // Short packets, ECC corrections and an uncorrectable syndrome.
      for (int i = 0; i < 8; i++) begin
         clear_log();
         send_hdr(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].b3);
         step(1'b0, 1'b0, 1'b0, 8'h00);
         if (vt[i].hv) begin
            last_vc = vt[i].vc; last_dt = vt[i].dt; last_wc = vt[i].wc;
         end
         check($sformatf("v%0d_hdr_valid", i), O_Hdr_Valid, vt[i].hv);
         check($sformatf("v%0d_ecc_error", i), O_Ecc_Error, vt[i].err);
         check($sformatf("v%0d_corrected", i), O_Ecc_Corrected, vt[i].corr);
         check($sformatf("v%0d_vc", i), O_Pkt_VC, last_vc);
         check($sformatf("v%0d_dt", i), O_Pkt_DT, last_dt);
         check($sformatf("v%0d_wc", i), O_Pkt_WC, last_wc);
         repeat (3) step(1'b0, 1'b0, 1'b1, 8'h5A);
         check($sformatf("v%0d_no_payload", i), n_pay, 0);
         check($sformatf("v%0d_busy_low", i), O_Busy, 0);
      end

      // Long packet WC=4 with CRC.
      clear_log();
      exp_pay[0] = 8'hAA; exp_pay[1] = 8'hBB; exp_pay[2] = 8'hCC; exp_pay[3] = 8'hDD;
      send_hdr(8'h2B, 8'h04, 8'h00, 8'h34);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("long_hv", O_Hdr_Valid, 1);
      check("long_dt", O_Pkt_DT, 6'h2B);
      check("long_wc", O_Pkt_WC, 16'h0004);
      check("long_corr", O_Ecc_Corrected, 0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 1'b1, exp_pay[k]);
         check($sformatf("long_pv%0d", k), O_Payload_Valid, 1);
         check($sformatf("long_pd%0d", k), O_Payload_Data, exp_pay[k]);
         check($sformatf("long_last%0d", k), O_Payload_Last, (k == 3) ? 1 : 0);
      end
      step(1'b0, 1'b0, 1'b1, 8'h11);
      check("long_crc0_fwd", O_Payload_Valid, 0);
      step(1'b0, 1'b0, 1'b1, 8'h22);
      check("long_crc1_fwd", O_Payload_Valid, 0);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("long_busy_low", O_Busy, 0);
      check("long_npay", n_pay, 4);

      // Double-bit error on a long header: dropped, following bytes ignored.
      clear_log();
      send_hdr(8'h28, 8'h04, 8'h00, 8'h34);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("dbl_err", O_Ecc_Error, 1);
      check("dbl_hv", O_Hdr_Valid, 0);
      check("dbl_wc_held", O_Pkt_WC, 16'h0004);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(k));
      check("dbl_err_pulse", O_Ecc_Error, 0);
      check("dbl_npay", n_pay, 0);
      check("dbl_busy", O_Busy, 0);

      // Lane drops to LP after two payload bytes.
      clear_log();
      send_hdr(8'h2B, 8'h04, 8'h00, 8'h34);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'hAA);
      step(1'b0, 1'b0, 1'b1, 8'hBB);
      step(1'b0, 1'b1, 1'b1, 8'hCC);
      check("end_abort", O_Pkt_Abort, 1);
      check("end_pv", O_Payload_Valid, 0);
      step(1'b0, 1'b0, 1'b1, 8'hDD);
      check("end_abort_pulse", O_Pkt_Abort, 0);
      check("end_busy", O_Busy, 0);
      check("end_npay", n_pay, 2);
      check("end_nlast", n_last, 0);

      // Stalling valid, first payload byte arriving during CHECK.
      clear_log();
      send_hdr(8'h2B, 8'h04, 8'h00, 8'h34);
      step(1'b0, 1'b0, 1'b1, 8'h01);
      check("stall_hv", O_Hdr_Valid, 1);
      check("stall_pv0", O_Payload_Valid, 1);
      for (int k = 2; k <= 4; k++) begin
         step(1'b0, 1'b0, 1'b0, 8'hFF);
         step(1'b0, 1'b0, 1'b1, 8'(k));
      end
      step(1'b0, 1'b0, 1'b0, 8'hFF);
      step(1'b0, 1'b0, 1'b1, 8'h11);
      step(1'b0, 1'b0, 1'b0, 8'hFF);
      check("stall_busy_crc", O_Busy, 1);
      step(1'b0, 1'b0, 1'b1, 8'h22);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("stall_busy_low", O_Busy, 0);
      check("stall_npay", n_pay, 4);
      for (int k = 0; k < 4; k++) begin
         if (k < pay_q.size()) check($sformatf("stall_pd%0d", k), pay_q[k], 8'(k + 1));
      end
      check("stall_nlast", n_last, 1);
      check("stall_last_byte", last_byte, 8'h04);

      // Long packet WC=0: the CHECK-cycle byte is CRC byte 0.
      clear_log();
      send_hdr(8'h10, 8'h00, 8'h00, 8'h13);
      step(1'b0, 1'b0, 1'b1, 8'h77);
      check("wc0_hv", O_Hdr_Valid, 1);
      check("wc0_dt", O_Pkt_DT, 6'h10);
      check("wc0_wc", O_Pkt_WC, 16'h0000);
      check("wc0_busy_crc", O_Busy, 1);
      step(1'b0, 1'b0, 1'b1, 8'h88);
      check("wc0_busy_low", O_Busy, 0);
      check("wc0_npay", n_pay, 0);

      // SoT while mid-payload restarts the header.
      clear_log();
      send_hdr(8'h2B, 8'h04, 8'h00, 8'h34);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'hAA);
      step(1'b1, 1'b0, 1'b1, 8'h55);
      check("restart_abort", O_Pkt_Abort, 1);
      check("restart_busy", O_Busy, 1);
      check("restart_pv", O_Payload_Valid, 0);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h01);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h1A);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("restart_hv", O_Hdr_Valid, 1);
      check("restart_wc", O_Pkt_WC, 16'h0001);
      check("restart_dt", O_Pkt_DT, 6'h00);
      check("restart_npay", n_pay, 1);

      // Asynchronous reset in the middle of a payload.
      clear_log();
      send_hdr(8'h2B, 8'h04, 8'h00, 8'h34);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'hAA);
      check("arst_pre_pv", O_Payload_Valid, 1);
      #2 I_rst_n = 1'b0;
      #1;
      check("arst_pv", O_Payload_Valid, 0);
      check("arst_busy", O_Busy, 0);
      check("arst_wc", O_Pkt_WC, 0);
      check("arst_abort", O_Pkt_Abort, 0);
      step(1'b0, 1'b0, 1'b1, 8'hBB);
      I_rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b1, 8'hCC);
      check("arst_post_abort", O_Pkt_Abort, 0);
      check("arst_post_pv", O_Payload_Valid, 0);
      check("arst_post_busy", O_Busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mipi_pkt_header_ctrl.md
# mipi_pkt_header_ctrl

Sequences CSI-2 packet reception on the merged byte stream of the MIPI receiver. The block collects the 4-byte packet header and runs it through the Hamming ECC check. It corrects single-bit errors, rejects uncorrectable headers, then counts long-packet payload and CRC bytes before re-arming for the next packet. It sits between the lane merger and the pixel unpacker.

## Interface
- `P_WC_WIDTH`, 16: word-count width.
- `I_clk` input 1: byte clock.
- `I_rst_n` input 1: one clock; reset is asynchronous and active-low.
- `I_Pkt_Start` input 1: SoT sync detected; the next valid byte is header byte 0.
- `I_Pkt_End` input 1: lane returned to LP; aborts any packet in progress.
- `I_Byte_Data` input 8: merged byte.
- `I_Byte_Valid` input 1: byte qualifier.
- `O_Hdr_Valid` output 1: one-cycle pulse; header fields valid.
- `O_Pkt_VC` output 2: virtual channel, DI[7:6].
- `O_Pkt_DT` output 6: data type, DI[5:0].
- `O_Pkt_WC` output 16: word count, {byte2, byte1}.
- `O_Ecc_Corrected` output 1: qualifies `O_Hdr_Valid`; a single-bit error was fixed.
- `O_Ecc_Error` output 1: one-cycle pulse; uncorrectable header, packet dropped.
- `O_Payload_Data` output 8: payload byte.
- `O_Payload_Valid` output 1: payload qualifier.
- `O_Payload_Last` output 1: final payload byte.
- `O_Pkt_Abort` output 1: one-cycle pulse; packet cut short.
- `O_Busy` output 1: state is not IDLE.

## Operation
- Header mapping: 24-bit data D = {byte2, byte1, byte0}, with byte0 (DI) in D[7:0]. Received ECC is byte3[5:0]. byte3[7:6] is ignored.
- Syndrome S = calc_ecc(D) XOR byte3[5:0].
  - S == 0: header is clean.
  - S equals the column of data bit i: flip D[i] and set corrected.
  - S is one-hot: the error is in an ECC bit. D is unchanged; set corrected.
  - Any other S: uncorrectable. Pulse `O_Ecc_Error`, emit no `O_Hdr_Valid`, return to IDLE.
- Packet class: DT 0x00–0x0F is a short packet; all other DT values are long packets.
- FSM states:
  - IDLE: goes to HDR on `I_Pkt_Start`.
  - HDR: accepts 4 valid bytes (counter 0..3). Goes to CHECK after byte3.
  - CHECK: lasts one cycle; syndrome is evaluated.
    - Short packet or uncorrectable header: next state is IDLE.
    - Long packet with WC = 0: next state is CRC.
    - Otherwise: next state is PAYLOAD.
  - PAYLOAD: forwards valid bytes and counts down WC. The byte that brings the count to 0 carries `O_Payload_Last`. Goes to CRC.
  - CRC: consumes 2 valid bytes without forwarding them. Goes to IDLE.
- Invalid cycles (`I_Byte_Valid` = 0) stall the counters in every state.
- Byte valid during CHECK:
  - Long packet with WC ≠ 0: the byte is treated as payload byte 0.
  - WC = 0: it counts as CRC byte 0.
  - Otherwise: it is discarded.
- Bytes arriving in IDLE without `I_Pkt_Start` are ignored.
- `I_Pkt_End` in HDR, CHECK, PAYLOAD or CRC: go to IDLE and pulse `O_Pkt_Abort`. This takes priority over a byte in the same cycle.
- `I_Pkt_Start` while not IDLE: pulse `O_Pkt_Abort`, then restart in HDR with the counter cleared.
- `I_Pkt_Start` and `I_Byte_Valid` in the same cycle: that byte is not header byte 0.

## Timing
- Every output resets to 0; the FSM resets to IDLE and all counters to 0.
- Header byte3 accepted in cycle N: CHECK is cycle N+1. `O_Hdr_Valid`/`O_Ecc_Error` and the field outputs are registered and appear in cycle N+2.
- VC/DT/WC hold their value until the next `O_Hdr_Valid`.
- Payload path has 1 cycle of latency: input byte in cycle M appears at the output in cycle M+1.
- `O_Busy` is registered. It is high from the cycle after `I_Pkt_Start` until the cycle after returning to IDLE.
- Reset asserted mid-packet clears everything immediately, with no abort pulse.

## Structure
- Package `mipi_csi2_pkg`:
  - DT short-packet range constant.
  - The 24-entry 6-bit syndrome column table. Each entry is the ECC of a one-hot D, consistent with the team's CSI-2 parity equations.
  - FSM state enum.
- One sub-module, `mipi_ecc_syndrome`: combinational. Inputs are D[23:0] and ECC[5:0]. Outputs are the corrected D, corrected flag and error flag. It contains the parity equations and the table lookup.

## Test plan
- Frame-start short packet 0x00 0x01 0x00 0x1A:
  - `O_Hdr_Valid` appears 2 cycles after byte3.
  - VC=0, DT=0x00, WC=0x0001, corrected=0.
  - No payload; `O_Busy` drops.
- Same packet with DI=0x01 (bit-0 error, S=0x07):
  - Fields as above, DT=0x00, `O_Ecc_Corrected`=1.
- Long packet 0x2B 0x04 0x00 0x34, then 4 payload bytes AA BB CC DD, then 2 CRC bytes:
  - DT=0x2B, WC=4.
  - Payload AA..DD appears one cycle delayed; `O_Payload_Last` is on DD.
  - CRC bytes are not forwarded; returns to IDLE.
- Same header with DI=0x28 (bits 0 and 1 flipped, S=0x0C):
  - `O_Ecc_Error` pulses; no `O_Hdr_Valid`.
  - Following bytes are ignored.
- Long packet WC=4 with `I_Pkt_End` after 2 payload bytes:
  - Exactly 2 payload outputs, no Last.
  - `O_Pkt_Abort` pulses; IDLE.
- Payload bytes with `I_Byte_Valid` toggling every cycle, plus a byte arriving in CHECK:
  - Count and data order are preserved.
